// File: rtl/fifos_interface_param.sv
// Two-direction mc<->sc FIFO interface with occupancy/almost-full status, registered read data,
// an outstanding-request limiter and optional sticky error flags (FIFOS_IF_ERR_FLAGS_EN).

module fifos_if_fifo #(
  parameter int DEPTH     = 32,
  parameter int LOG2      = 5,
  parameter int W         = 70,
  parameter int AF_LEVEL  = 28
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wr,
  input  logic [W-1:0]    i_wdata,
  input  logic            i_rd,
  output logic [W-1:0]    o_rdata,
  output logic            o_rvalid,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_almost_full,
  output logic [LOG2:0]   o_count
);

  localparam int C = LOG2 + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [LOG2-1:0] r_wptr;
  logic [LOG2-1:0] r_rptr;
  logic [C-1:0]    r_count;
  logic [C-1:0]    w_count_nxt;
  logic            r_empty;
  logic            r_full;
  logic            r_almost_full;
  logic [W-1:0]    r_rdata;
  logic            r_rvalid;

  always_comb begin
    w_count_nxt = r_count;
    if (i_wr && !i_rd)
      w_count_nxt = r_count + 1'b1;
    else if (!i_wr && i_rd)
      w_count_nxt = r_count - 1'b1;
  end

  // Storage is not reset: contents are unreachable once pointers and count clear.
  always_ff @(posedge clk) begin
    if (i_wr)
      r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
    end else begin
      if (i_wr)
        r_wptr <= r_wptr + 1'b1;
      if (i_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      r_rvalid      <= i_rd;
      r_count       <= w_count_nxt;
      r_empty       <= (w_count_nxt == '0);
      r_full        <= (w_count_nxt == C'(DEPTH));
      r_almost_full <= (w_count_nxt >= C'(AF_LEVEL));
    end
  end

  assign o_rdata       = r_rdata;
  assign o_rvalid      = r_rvalid;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;
  assign o_count       = r_count;

endmodule

module fifos_interface_param #(
  parameter int FIFO_DEPTH         = 32,
  parameter int LOG2_FIFO_DEPTH    = 5,
  parameter int DATA_LINE_WIDTH    = 64,
  parameter int CONTROL_LINE_WIDTH = 6,
  parameter int ALMOST_FULL_LEVEL  = 28,
  parameter int MAX_OUTSTANDING    = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] i_mc_sreq_inbits,
  input  logic                                          i_mc_sreq_wen,
  output logic                                          o_mc_sreq_fifo_empty,
  output logic                                          o_mc_sreq_fifo_full,
  output logic                                          o_mc_sreq_almost_full,
  output logic [LOG2_FIFO_DEPTH:0]                      o_mc_sreq_count,
  input  logic                                          i_sc_rreq_ren,
  output logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] o_sc_rreq_outbits,
  output logic                                          o_sc_rreq_valid,
  output logic                                          o_sc_rreq_throttled,
  input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] i_sc_sresp_inbits,
  input  logic                                          i_sc_sresp_wen,
  output logic                                          o_sc_sresp_fifo_empty,
  output logic                                          o_sc_sresp_fifo_full,
  output logic                                          o_sc_sresp_almost_full,
  output logic [LOG2_FIFO_DEPTH:0]                      o_sc_sresp_count,
  input  logic                                          i_mc_rresp_ren,
  output logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] o_mc_rresp_outbits,
  output logic                                          o_mc_rresp_valid,
  output logic [LOG2_FIFO_DEPTH:0]                      o_outstanding,
  input  logic                                          i_err_clr,
  output logic [4:0]                                    o_err
);

  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
  localparam int C = LOG2_FIFO_DEPTH + 1;

  logic         w_req_wr;
  logic         w_req_rd;
  logic         w_resp_wr;
  logic         w_resp_rd;
  logic         w_req_empty;
  logic         w_req_full;
  logic         w_resp_empty;
  logic         w_resp_full;
  logic [C-1:0] r_outstanding;
  logic [C-1:0] w_outstanding_nxt;
  logic         r_throttled;

  assign w_req_wr  = i_mc_sreq_wen && !w_req_full;
  assign w_req_rd  = i_sc_rreq_ren && !w_req_empty && !r_throttled;
  // A request popped this cycle already counts as outstanding for a same-cycle response.
  assign w_resp_wr = i_sc_sresp_wen && !w_resp_full && ((r_outstanding != '0) || w_req_rd);
  assign w_resp_rd = i_mc_rresp_ren && !w_resp_empty;

  fifos_if_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .LOG2     (LOG2_FIFO_DEPTH),
    .W        (W),
    .AF_LEVEL (ALMOST_FULL_LEVEL)
  ) u_req_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr          (w_req_wr),
    .i_wdata       (i_mc_sreq_inbits),
    .i_rd          (w_req_rd),
    .o_rdata       (o_sc_rreq_outbits),
    .o_rvalid      (o_sc_rreq_valid),
    .o_empty       (w_req_empty),
    .o_full        (w_req_full),
    .o_almost_full (o_mc_sreq_almost_full),
    .o_count       (o_mc_sreq_count)
  );

  fifos_if_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .LOG2     (LOG2_FIFO_DEPTH),
    .W        (W),
    .AF_LEVEL (ALMOST_FULL_LEVEL)
  ) u_resp_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr          (w_resp_wr),
    .i_wdata       (i_sc_sresp_inbits),
    .i_rd          (w_resp_rd),
    .o_rdata       (o_mc_rresp_outbits),
    .o_rvalid      (o_mc_rresp_valid),
    .o_empty       (w_resp_empty),
    .o_full        (w_resp_full),
    .o_almost_full (o_sc_sresp_almost_full),
    .o_count       (o_sc_sresp_count)
  );

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_req_rd && !w_resp_wr)
      w_outstanding_nxt = r_outstanding + 1'b1;
    else if (!w_req_rd && w_resp_wr)
      w_outstanding_nxt = r_outstanding - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_throttled   <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_throttled   <= (w_outstanding_nxt == C'(MAX_OUTSTANDING));
    end
  end

  assign o_mc_sreq_fifo_empty  = w_req_empty;
  assign o_mc_sreq_fifo_full   = w_req_full;
  assign o_sc_sresp_fifo_empty = w_resp_empty;
  assign o_sc_sresp_fifo_full  = w_resp_full;
  assign o_outstanding         = r_outstanding;
  assign o_sc_rreq_throttled   = r_throttled;

`ifdef FIFOS_IF_ERR_FLAGS_EN
  logic [4:0] w_err_set;
  logic [4:0] r_err;

  always_comb begin
    w_err_set    = '0;
    w_err_set[0] = i_mc_sreq_wen && w_req_full;
    w_err_set[1] = i_sc_rreq_ren && (w_req_empty || r_throttled);
    w_err_set[2] = i_sc_sresp_wen && w_resp_full;
    w_err_set[3] = i_mc_rresp_ren && w_resp_empty;
    w_err_set[4] = i_sc_sresp_wen && !w_resp_full && (r_outstanding == '0) && !w_req_rd;
  end

  // New error events win over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= '0;
    else
      r_err <= (i_err_clr ? 5'd0 : r_err) | w_err_set;
  end

  assign o_err = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = i_err_clr;
  assign o_err = '0;
`endif

endmodule

// File: tb/tb_fifos_interface_param.sv
// Directed bench for fifos_interface_param: queue-based reference model compared every cycle,
// plus hand-computed expectations; error-flag expectations follow FIFOS_IF_ERR_FLAGS_EN.

module tb_fifos_interface_param;

  localparam int D  = 32;
  localparam int LG = 5;
  localparam int W  = 70;
  localparam int C  = 6;
  localparam int AF = 28;
  localparam int MX = 16;
`ifdef FIFOS_IF_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] i_mc_sreq_inbits;
  logic         i_mc_sreq_wen;
  logic         o_mc_sreq_fifo_empty, o_mc_sreq_fifo_full, o_mc_sreq_almost_full;
  logic [C-1:0] o_mc_sreq_count;
  logic         i_sc_rreq_ren;
  logic [W-1:0] o_sc_rreq_outbits;
  logic         o_sc_rreq_valid, o_sc_rreq_throttled;
  logic [W-1:0] i_sc_sresp_inbits;
  logic         i_sc_sresp_wen;
  logic         o_sc_sresp_fifo_empty, o_sc_sresp_fifo_full, o_sc_sresp_almost_full;
  logic [C-1:0] o_sc_sresp_count;
  logic         i_mc_rresp_ren;
  logic [W-1:0] o_mc_rresp_outbits;
  logic         o_mc_rresp_valid;
  logic [C-1:0] o_outstanding;
  logic         i_err_clr;
  logic [4:0]   o_err;

  fifos_interface_param #(
    .FIFO_DEPTH(D), .LOG2_FIFO_DEPTH(LG), .DATA_LINE_WIDTH(64), .CONTROL_LINE_WIDTH(6),
    .ALMOST_FULL_LEVEL(AF), .MAX_OUTSTANDING(MX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mc_sreq_inbits(i_mc_sreq_inbits), .i_mc_sreq_wen(i_mc_sreq_wen),
    .o_mc_sreq_fifo_empty(o_mc_sreq_fifo_empty), .o_mc_sreq_fifo_full(o_mc_sreq_fifo_full),
    .o_mc_sreq_almost_full(o_mc_sreq_almost_full), .o_mc_sreq_count(o_mc_sreq_count),
    .i_sc_rreq_ren(i_sc_rreq_ren), .o_sc_rreq_outbits(o_sc_rreq_outbits),
    .o_sc_rreq_valid(o_sc_rreq_valid), .o_sc_rreq_throttled(o_sc_rreq_throttled),
    .i_sc_sresp_inbits(i_sc_sresp_inbits), .i_sc_sresp_wen(i_sc_sresp_wen),
    .o_sc_sresp_fifo_empty(o_sc_sresp_fifo_empty), .o_sc_sresp_fifo_full(o_sc_sresp_fifo_full),
    .o_sc_sresp_almost_full(o_sc_sresp_almost_full), .o_sc_sresp_count(o_sc_sresp_count),
    .i_mc_rresp_ren(i_mc_rresp_ren), .o_mc_rresp_outbits(o_mc_rresp_outbits),
    .o_mc_rresp_valid(o_mc_rresp_valid), .o_outstanding(o_outstanding),
    .i_err_clr(i_err_clr), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queues for the two FIFOs, an integer outstanding count, sticky error word.
  logic [W-1:0] m_req_q[$];
  logic [W-1:0] m_resp_q[$];
  logic [W-1:0] m_req_out, m_resp_out;
  bit           m_req_v, m_resp_v;
  int           m_outst;
  logic [4:0]   m_err;

  always @(posedge clk or negedge rst_n) begin : model
    int   rq, sq;
    bit   thr, wr_ok, pop, push, rpop;
    logic [4:0] set;
    if (!rst_n) begin
      m_req_q.delete();
      m_resp_q.delete();
      m_req_out  = '0;
      m_resp_out = '0;
      m_req_v    = 1'b0;
      m_resp_v   = 1'b0;
      m_outst    = 0;
      m_err      = '0;
    end else begin
      rq    = m_req_q.size();
      sq    = m_resp_q.size();
      thr   = (m_outst == MX);
      wr_ok = i_mc_sreq_wen && (rq < D);
      pop   = i_sc_rreq_ren && (rq > 0) && !thr;
      push  = i_sc_sresp_wen && (sq < D) && (m_outst > 0 || pop);
      rpop  = i_mc_rresp_ren && (sq > 0);
      set      = '0;
      set[0]   = i_mc_sreq_wen && (rq == D);
      set[1]   = i_sc_rreq_ren && ((rq == 0) || thr);
      set[2]   = i_sc_sresp_wen && (sq == D);
      set[3]   = i_mc_rresp_ren && (sq == 0);
      set[4]   = i_sc_sresp_wen && (sq < D) && (m_outst == 0) && !pop;
      m_req_v  = pop;
      if (pop) m_req_out = m_req_q.pop_front();
      if (wr_ok) m_req_q.push_back(i_mc_sreq_inbits);
      m_resp_v = rpop;
      if (rpop) m_resp_out = m_resp_q.pop_front();
      if (push) m_resp_q.push_back(i_sc_sresp_inbits);
      m_outst  = m_outst + int'(pop) - int'(push);
      m_err    = (i_err_clr ? 5'd0 : m_err) | set;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_count",  W'(o_mc_sreq_count), W'(m_req_q.size()));
      chk("req_empty",  W'(o_mc_sreq_fifo_empty), W'(m_req_q.size() == 0));
      chk("req_full",   W'(o_mc_sreq_fifo_full), W'(m_req_q.size() == D));
      chk("req_af",     W'(o_mc_sreq_almost_full), W'(m_req_q.size() >= AF));
      chk("resp_count", W'(o_sc_sresp_count), W'(m_resp_q.size()));
      chk("resp_empty", W'(o_sc_sresp_fifo_empty), W'(m_resp_q.size() == 0));
      chk("resp_full",  W'(o_sc_sresp_fifo_full), W'(m_resp_q.size() == D));
      chk("resp_af",    W'(o_sc_sresp_almost_full), W'(m_resp_q.size() >= AF));
      chk("rreq_valid", W'(o_sc_rreq_valid), W'(m_req_v));
      chk("rreq_data",  o_sc_rreq_outbits, m_req_out);
      chk("rresp_valid", W'(o_mc_rresp_valid), W'(m_resp_v));
      chk("rresp_data", o_mc_rresp_outbits, m_resp_out);
      chk("outstanding", W'(o_outstanding), W'(m_outst));
      chk("throttled",  W'(o_sc_rreq_throttled), W'(m_outst == MX));
      chk("err",        W'(o_err), ERR_EN ? W'(m_err) : W'(0));
    end
  end

  task automatic idle_inputs();
    i_mc_sreq_wen  = 1'b0;
    i_sc_rreq_ren  = 1'b0;
    i_sc_sresp_wen = 1'b0;
    i_mc_rresp_ren = 1'b0;
    i_err_clr      = 1'b0;
  endtask

  initial begin
    int npulse;
    idle_inputs();
    i_mc_sreq_inbits  = '0;
    i_sc_sresp_inbits = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_req_empty", W'(o_mc_sreq_fifo_empty), W'(1));
    chk("rst_req_count", W'(o_mc_sreq_count), W'(0));
    chk("rst_outst", W'(o_outstanding), W'(0));

    // Fill with 70 words; the tail is dropped once full.
    for (int i = 0; i < 70; i++) begin
      if (i == 27) chk("af_27", W'(o_mc_sreq_almost_full), W'(0));
      if (i == 28) chk("af_28", W'(o_mc_sreq_almost_full), W'(1));
      if (i == 31) chk("full_31", W'(o_mc_sreq_fifo_full), W'(0));
      if (i == 32) begin
        chk("full_32", W'(o_mc_sreq_fifo_full), W'(1));
        chk("count_32", W'(o_mc_sreq_count), W'(32));
      end
      i_mc_sreq_wen    = 1'b1;
      i_mc_sreq_inbits = W'(i);
      @(negedge clk);
    end
    i_mc_sreq_wen = 1'b0;
    chk("count_after_fill", W'(o_mc_sreq_count), W'(32));
    chk("err0_overflow", W'(o_err[0]), W'(ERR_EN));

    // Held read: limiter stops delivery at 16 outstanding.
    npulse = 0;
    i_sc_rreq_ren = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_sc_rreq_valid) begin
        chk("burst_data", o_sc_rreq_outbits, W'(npulse));
        npulse++;
      end
    end
    i_sc_rreq_ren = 1'b0;
    chk("pulses", W'(npulse), W'(16));
    chk("throttled_16", W'(o_sc_rreq_throttled), W'(1));
    chk("outst_16", W'(o_outstanding), W'(16));
    chk("count_16", W'(o_mc_sreq_count), W'(16));
    chk("err1_throttle", W'(o_err[1]), W'(ERR_EN));

    // One response frees one slot; the next read delivers word 16.
    i_sc_sresp_wen    = 1'b1;
    i_sc_sresp_inbits = W'('h100);
    @(negedge clk);
    i_sc_sresp_wen = 1'b0;
    chk("outst_15", W'(o_outstanding), W'(15));
    chk("unthrottled", W'(o_sc_rreq_throttled), W'(0));
    i_sc_rreq_ren = 1'b1;
    @(negedge clk);
    i_sc_rreq_ren = 1'b0;
    chk("word16_valid", W'(o_sc_rreq_valid), W'(1));
    chk("word16_data", o_sc_rreq_outbits, W'(16));

    for (int i = 0; i < 16; i++) begin
      i_sc_sresp_wen    = 1'b1;
      i_sc_sresp_inbits = W'('h200 + i);
      @(negedge clk);
    end
    i_sc_sresp_wen = 1'b0;
    chk("outst_0", W'(o_outstanding), W'(0));
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr         = 1'b0;
    i_sc_sresp_wen    = 1'b1;
    i_sc_sresp_inbits = W'('hDEAD);
    @(negedge clk);
    i_sc_sresp_wen = 1'b0;
    chk("orphan_err", W'(o_err), ERR_EN ? W'(5'b10000) : W'(0));
    chk("orphan_count", W'(o_sc_sresp_count), W'(17));

    // Drain responses, then an empty read that races a clear.
    for (int i = 0; i < 17; i++) begin
      if (i == 1) chk("resp_first", o_mc_rresp_outbits, W'('h100));
      i_mc_rresp_ren = 1'b1;
      @(negedge clk);
    end
    chk("resp_last", o_mc_rresp_outbits, W'('h20F));
    i_err_clr = 1'b1;
    @(negedge clk);
    i_mc_rresp_ren = 1'b0;
    i_err_clr      = 1'b0;
    chk("set_beats_clr", W'(o_err), ERR_EN ? W'(5'b01000) : W'(0));
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    chk("clr_alone", W'(o_err), W'(0));

    // Bring request count to 10, then simultaneous push/pop long enough to wrap pointers.
    i_sc_rreq_ren = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (i == 1) begin
        chk("sim_first_data", o_sc_rreq_outbits, W'(22));
        chk("sim_count", W'(o_mc_sreq_count), W'(10));
      end
      i_mc_sreq_wen     = 1'b1;
      i_mc_sreq_inbits  = W'(1000 + i);
      i_sc_rreq_ren     = 1'b1;
      i_sc_sresp_wen    = 1'b1;
      i_sc_sresp_inbits = W'(3000 + i);
      i_mc_rresp_ren    = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    chk("sim_last_data", o_sc_rreq_outbits, W'(1029));
    chk("sim_count_end", W'(o_mc_sreq_count), W'(10));
    chk("sim_outst", W'(o_outstanding), W'(5));

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) begin
      i_mc_sreq_wen    = 1'b1;
      i_mc_sreq_inbits = W'(2000 + i);
      i_sc_rreq_ren    = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", W'(o_mc_sreq_count), W'(0));
    chk("arst_empty", W'(o_mc_sreq_fifo_empty), W'(1));
    chk("arst_valid", W'(o_sc_rreq_valid), W'(0));
    chk("arst_data", o_sc_rreq_outbits, W'(0));
    chk("arst_outst", W'(o_outstanding), W'(0));
    chk("arst_resp_count", W'(o_sc_sresp_count), W'(0));
    chk("arst_err", W'(o_err), W'(0));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_mc_sreq_wen    = 1'b1;
    i_mc_sreq_inbits = W'('hABC);
    @(negedge clk);
    i_mc_sreq_wen = 1'b0;
    i_sc_rreq_ren = 1'b1;
    @(negedge clk);
    i_sc_rreq_ren = 1'b0;
    chk("post_rst_valid", W'(o_sc_rreq_valid), W'(1));
    chk("post_rst_data", o_sc_rreq_outbits, W'('hABC));
    @(negedge clk);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifos_interface_param.md
# fifos_interface_param

Parametrised two-direction FIFO interface between a master controller (mc) and a slave controller (sc). It carries requests mc→sc and responses sc→mc. Over the fixed-size two-FIFO interface it adds:
- configurable width and depth;
- occupancy counts and almost-full flags;
- registered read data with a valid strobe;
- an outstanding-request limiter that throttles request delivery;
- sticky error reporting.

It sits at the protocol boundary, with one mc-side port pair and one sc-side port pair.

## Interface
Parameters:
- FIFO_DEPTH, 32, entries per FIFO; power of two, ≥ 4.
- LOG2_FIFO_DEPTH, 5, log2(FIFO_DEPTH).
- DATA_LINE_WIDTH, 64, data bits per entry.
- CONTROL_LINE_WIDTH, 6, control bits per entry; entry width W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH.
- ALMOST_FULL_LEVEL, 28, occupancy at or above which almost_full asserts; 1..FIFO_DEPTH.
- MAX_OUTSTANDING, 16, maximum requests delivered to sc without a matching response; 1..FIFO_DEPTH.

Ports (C = LOG2_FIFO_DEPTH+1):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_mc_sreq_inbits  in  W  request write data.
- i_mc_sreq_wen  in  1  request write enable.
- o_mc_sreq_fifo_empty / o_mc_sreq_fifo_full / o_mc_sreq_almost_full  out  1  request FIFO status.
- o_mc_sreq_count  out  C  request FIFO occupancy.
- i_sc_rreq_ren  in  1  request read enable.
- o_sc_rreq_outbits  out  W  request read data (registered).
- o_sc_rreq_valid  out  1  o_sc_rreq_outbits is valid this cycle.
- o_sc_rreq_throttled  out  1  outstanding == MAX_OUTSTANDING.
- i_sc_sresp_inbits  in  W  response write data.
- i_sc_sresp_wen  in  1  response write enable.
- o_sc_sresp_fifo_empty / o_sc_sresp_fifo_full / o_sc_sresp_almost_full  out  1  response FIFO status.
- o_sc_sresp_count  out  C  response FIFO occupancy.
- i_mc_rresp_ren  in  1  response read enable.
- o_mc_rresp_outbits  out  W  response read data (registered).
- o_mc_rresp_valid  out  1  o_mc_rresp_outbits is valid this cycle.
- o_outstanding  out  C  requests delivered minus responses accepted.
- i_err_clr  in  1  clears o_err.
- o_err  out  5  sticky errors:
  - [0] request overflow;
  - [1] request underflow/throttled read;
  - [2] response overflow;
  - [3] response underflow;
  - [4] orphan response.

## Operation
- Each FIFO is circular storage with LOG2_FIFO_DEPTH-bit read and write pointers that wrap modulo FIFO_DEPTH, plus a C-bit count.
  - empty = (count == 0); full = (count == FIFO_DEPTH); almost_full = (count ≥ ALMOST_FULL_LEVEL).
- Request write is accepted when i_mc_sreq_wen && !full. If full, the write is dropped and err[0] is set.
- Request read is accepted when i_sc_rreq_ren && !empty && !throttled.
  - An accepted read pops the entry into o_sc_rreq_outbits, pulses o_sc_rreq_valid, and increments outstanding.
  - A rejected read (empty or throttled) sets err[1]; data and valid are unchanged and valid is 0 the next cycle.
- Response write is accepted when i_sc_sresp_wen && !full && outstanding > 0 (after any same-cycle request pop).
  - An accepted write decrements outstanding.
  - Full: drop the write and set err[2].
  - outstanding == 0 with no same-cycle pop: drop the write and set err[4].
- Response read is accepted when i_mc_rresp_ren && !empty. If empty, err[3] is set.
- Simultaneous accepted write and read on one FIFO: count unchanged and both pointers advance.
  - Status is evaluated before the edge, so a write to a full FIFO is dropped even with a same-cycle read.
  - A read from an empty FIFO is rejected even with a same-cycle write. No write-through.
- Same-cycle request pop and response push: outstanding unchanged.
- Error bits: set has priority over i_err_clr in the same cycle.
- Reset (asynchronous, at any time, mid-transfer included):
  - pointers, counts, outstanding and o_err go to 0;
  - outbits go to 0 and valids to 0;
  - empty = 1, full = 0, almost_full = 0, throttled = 0;
  - FIFO contents are discarded.

## Timing
- Write-to-readable latency: 1 cycle. An entry written at edge N clears empty after N and can be read at edge N+1.
- Read latency: 1 cycle. With ren sampled at edge N, outbits and valid are updated after N. valid is high for exactly one cycle per accepted read.
- Back-to-back reads every cycle sustain 1 entry/cycle.
- count, flags, outstanding and throttled are registered and update after the accepting edge.

## Configuration
- FIFOS_IF_ERR_FLAGS_EN defined: o_err logic and i_err_clr are implemented as above.
- Not defined: o_err is tied to 0 and i_err_clr is ignored.
- Drop and reject behaviour is identical either way.

## Test plan
- Reset, then write 70 words (values 0..69) with wen held high → count reaches 32 and full asserts after the 32nd write; almost_full asserts after the 28th; words 32..69 are dropped and err[0] = 1.
- With MAX_OUTSTANDING=16, hold i_sc_rreq_ren for 20 cycles → 16 valid pulses with data 0..15; throttled = 1 and outstanding = 16; err[1] = 1; request count = 16.
- Push 1 response → outstanding = 15; next held read delivers word 16; response with outstanding 0 → dropped, err[4] = 1.
- Simultaneous request write and read at count 10 → count stays 10, read data is the oldest entry; repeat through 40 cycles so pointers wrap and data order is preserved.
- Assert rst_n low mid-burst, asynchronously between edges → all outputs reach their reset values immediately; after release, the first write/read returns the new data.
- Set err[3] while asserting i_err_clr in the same cycle → err[3] remains 1; i_err_clr alone next cycle → o_err = 0. With the macro undefined, o_err stays 0 throughout.
